iterative_alu: RTL and testbench
================================

// Module: iterative_alu
// PURPOSE
//  Execution-side consumer of the 4-bit ALU control code and operands.
//  Sits between decode/regfile and writeback.
//  Logic/arith ops complete in one cycle; shifts iterate one bit per cycle.
//  valid/ready on both sides.
// PARAMETERS
//  WIDTH    32               operand/result width
//  SHAMT_W  $clog2(WIDTH)    shift-amount width (b[SHAMT_W-1:0])
// PORTS
//  clk         in   1        rising-edge clock
//  rst_n       in   1        async active-low reset
//  flush       in   1        sync abort: drop op in flight, go IDLE
//  in_valid    in   1        op/operands valid
//  in_ready    out  1        1 only in IDLE
//  alu_ctrl    in   4        operation code (table below)
//  a           in   WIDTH    operand A
//  b           in   WIDTH    operand B (shift amount = b[SHAMT_W-1:0])
//  out_valid   out  1        result valid (DONE state)
//  out_ready   in   1        consumer accepts result
//  result      out  WIDTH    registered result
//  zero        out  1        result == 0 (registered with result)
//  illegal     out  1        code not in table (registered with result)
// BEHAVIOUR
//  Codes: 0000 add | 0001 sub | 0010 and | 0011 or | 0100 sll | 0101 slt (signed, 0/1)
//         0110 srl | 0111 sra | 1000 sge (signed a>=b, 0/1) | 1001 xor
//  Any other code: result=0, zero=1, illegal=1.
//  Arithmetic is modulo 2^WIDTH; no overflow/carry outputs.
//  Reset (async, rst_n=0): state=IDLE; result=0; zero=0; illegal=0;
//   out_valid=0; in_ready=1; shift counter=0.
//  FSM IDLE -> (non-shift accept) DONE
//      IDLE -> (shift accept) SHIFT -> DONE -> IDLE
//  Accept = in_valid & in_ready at edge E0; alu_ctrl, a, b captured at E0.
//   Inputs are don't-care after E0.
//  Non-shift: result/zero/illegal written at E0; out_valid=1 after E0.
//  Shift, n = b[SHAMT_W-1:0]:
//   - E0 loads acc=a, cnt=n.
//   - Each SHIFT edge with cnt!=0: shift acc 1 bit, cnt-1.
//     sll fills 0; srl fills 0; sra fills acc MSB.
//   - Edge with cnt==0: result=acc, go DONE.
//   - out_valid=1 after E(n+1); n=0 -> after E1, result=a.
//  DONE: result/zero/illegal/out_valid held stable until out_ready=1.
//   - Edge with out_valid & out_ready -> IDLE.
//   - in_ready=0 in DONE; no same-cycle re-accept, so max throughput is 1 op / 2 cycles.
//  flush=1 at an edge: state=IDLE, out_valid=0, cnt=0, result unchanged.
//   - Overrides accept and out handshake in the same cycle.
//  rst_n low mid-SHIFT/DONE: immediate return to reset values; op discarded.
//  in_ready and out_valid are pure decodes of state; never both 1.
// TESTING
//  T1 add a=5,b=3 -> out_valid after E0, result=8, zero=0, illegal=0.
//  T2 sub a=b=0x1234 -> result=0, zero=1.
//     sub a=0,b=1 -> result=0xFFFFFFFF.
//  T3 sll a=1,b=31 -> out_valid after E32, result=0x80000000.
//     b=0 -> after E1, result=1.
//  T4 sra a=0x80000000,b=4 -> 0xF8000000.
//     srl same operands -> 0x08000000.
//     slt a=-1,b=1 -> 1; sge a=-1,b=1 -> 0.
//  T5 backpressure: out_ready=0 for 10 cycles in DONE.
//     -> result stable, in_ready=0, in_valid ignored; pulse out_ready -> IDLE next edge.
//  T6 flush at cycle 5 of sll b=20 -> IDLE, no out_valid.
//     rst_n pulse mid-shift -> reset values.
//     code 1111 -> result=0, illegal=1.

Source files
------------

// File: rtl/iterative_alu.sv
// iterative_alu: single-cycle logic/arith ops, one-bit-per-cycle shifts, valid/ready on both sides
//   clk, rst_n (async active-low), flush (sync abort)
//   in_valid/in_ready, alu_ctrl[3:0], a/b[WIDTH-1:0]  : operation input
//   out_valid/out_ready, result[WIDTH-1:0], zero, illegal : registered result output
module iterative_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_d;
    logic [WIDTH-1:0]   acc, alu_res, acc_d;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         sop;
    logic               is_shift, alu_ill;
    // shift codes 0100/0110/0111; low two bits select sll(00)/srl(10)/sra(11)
    assign is_shift  = (alu_ctrl == 4'b0100) || (alu_ctrl == 4'b0110) || (alu_ctrl == 4'b0111);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign acc_d     = (sop == 2'b00) ? {acc[WIDTH-2:0], 1'b0} : {sop[0] & acc[WIDTH-1], acc[WIDTH-1:1]};
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_res = a + b;
            4'b0001: alu_res = a - b;
            4'b0010: alu_res = a & b;
            4'b0011: alu_res = a | b;
            4'b0101: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            4'b1000: alu_res = {{(WIDTH-1){1'b0}}, $signed(a) >= $signed(b)};
            4'b1001: alu_res = a ^ b;
            default: alu_ill = !is_shift;
        endcase
    end
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = in_valid ? (is_shift ? SHIFT : DONE) : IDLE;
            SHIFT:   state_d = (cnt == '0) ? DONE : SHIFT;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            sop     <= 2'b00;
        end else if (flush) begin
            cnt <= '0;
        end else if (state == IDLE && in_valid) begin
            if (is_shift) begin
                acc <= a;
                cnt <= b[SHAMT_W-1:0];
                sop <= alu_ctrl[1:0];
            end else begin
                result  <= alu_res;
                zero    <= (alu_res == '0);
                illegal <= alu_ill;
            end
        end else if (state == SHIFT) begin
            if (cnt != '0) begin
                acc <= acc_d;
                cnt <= cnt - SHAMT_W'(1);
            end else begin
                result  <= acc;
                zero    <= (acc == '0);
                illegal <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed vectors with hand-computed results for iterative_alu
module tb_iterative_alu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = 4'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    int          tests = 0;
    int          fails = 0;
    always #5 clk = ~clk;
    iterative_alu dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic start_op(input logic [3:0] c, input logic [31:0] xa, input logic [31:0] xb);
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = c; a = xa; b = xb;
        @(posedge clk); #1;
        in_valid = 1'b0; alu_ctrl = 4'b1010; a = 32'hDEAD_BEEF; b = 32'h0000_0003;
    endtask
    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, {31'b0, in_ready}, 32'd1);
    endtask
    // lat = number of edges from E0 (inclusive) until out_valid is seen
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] xa,
                          input logic [31:0] xb, input logic [31:0] er, input logic ez,
                          input logic ei, input int elat, input bit hold);
        int lat;
        start_op(c, xa, xb);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        check({tag, "_res"}, result, er);
        check({tag, "_flags"}, {30'b0, zero, illegal}, {30'b0, ez, ei});
        if (!hold) release_out(tag);
    endtask
    initial begin
        int bad;
        #2;
        check("rst_state", {27'b0, in_ready, out_valid, zero, illegal, |result}, 32'b10000);
        #20 rst_n = 1'b1;
        run_op("add",     4'b0000, 32'd5,        32'd3,        32'd8,        1'b0, 1'b0, 1,  0);
        run_op("sub_eq",  4'b0001, 32'h1234,     32'h1234,     32'd0,        1'b1, 1'b0, 1,  0);
        run_op("sub_neg", 4'b0001, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0, 1,  0);
        run_op("sll31",   4'b0100, 32'd1,        32'd31,       32'h80000000, 1'b0, 1'b0, 33, 0);
        run_op("sll0",    4'b0100, 32'd1,        32'd0,        32'd1,        1'b0, 1'b0, 2,  0);
        run_op("sra4",    4'b0111, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, 6,  0);
        run_op("srl4",    4'b0110, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, 6,  0);
        run_op("slt",     4'b0101, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0, 1,  0);
        run_op("sge",     4'b1000, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0, 1,  0);
        run_op("and",     4'b0010, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0, 1,  0);
        run_op("or",      4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0, 1'b0, 1,  0);
        run_op("xor",     4'b1001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1'b0, 1,  1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1; alu_ctrl = 4'b0000; a = 32'd1; b = 32'd1;
            @(posedge clk); #1;
            if (result !== 32'hFF00FF00 || !out_valid || in_ready) bad++;
        end
        in_valid = 1'b0;
        check("bp_stable", 32'(bad), 32'd0);
        release_out("bp");
        check("bp_no_valid", {31'b0, out_valid}, 32'd0);
        start_op(4'b0100, 32'd1, 32'd20);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_state", {30'b0, in_ready, out_valid}, 32'b10);
        check("flush_res", result, 32'hFF00FF00);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) bad++;
        end
        check("flush_quiet", 32'(bad), 32'd0);
        run_op("sge_t",   4'b1000, 32'd7,        32'd7,        32'd1,        1'b0, 1'b0, 1,  0);
        start_op(4'b0100, 32'd1, 32'd20);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid", {27'b0, in_ready, out_valid, zero, illegal, |result}, 32'b10000);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("ill",     4'b1111, 32'd9,        32'd9,        32'd0,        1'b1, 1'b1, 1,  0);
        run_op("ill_b",   4'b1011, 32'd1,        32'd2,        32'd0,        1'b1, 1'b1, 1,  0);
        run_op("post",    4'b0000, 32'hFFFFFFFF, 32'd2,        32'd1,        1'b0, 1'b0, 1,  0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
